// File: rtl/src_data_sel_reg_if.sv
// Bundle for src_data_sel_reg: channel bus, selection controls, registered
// output and FSM debug state. The master drives inputs and the slave is the selector.
interface src_data_sel_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 9,
  parameter int SEL_W = 4
);
  logic [N*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]   control;
  logic               sel_load;
  logic               hold;
  logic               scan_en;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               scan_wrap;
  logic [1:0]         dbg_state;

  modport master (
    output in_bus, control, sel_load, hold, scan_en,
    input  out, out_valid, cur_sel, scan_wrap, dbg_state
  );

  modport slave (
    input  in_bus, control, sel_load, hold, scan_en,
    output out, out_valid, cur_sel, scan_wrap, dbg_state
  );
endinterface

// File: rtl/src_data_sel_reg.sv
// Registered N-way source-data selector with strobe-latched selection.
// Auto-scan (SCAN state, scan_en, scan_wrap) exists only with SRC_DATA_SEL_SCAN_EN.
module src_data_sel_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 9,
  parameter int SEL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  src_data_sel_reg_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] w_clamped;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic             w_scan_req;
  logic [WIDTH-1:0] w_ch [N];

  for (genvar k = 0; k < N; k++) begin : g_ch
    assign w_ch[k] = bus.in_bus[k*WIDTH +: WIDTH];
  end

  // Out-of-range indices select the last channel.
  assign w_clamped = (bus.control > LAST) ? LAST : bus.control;

`ifdef SRC_DATA_SEL_SCAN_EN
  assign w_scan_req = bus.scan_en;
`else
  logic w_unused_scan_en;
  assign w_unused_scan_en = bus.scan_en;
  assign w_scan_req       = 1'b0;
`endif

  // Priority: hold, then scan request, then sel_load.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_wrap_nxt  = 1'b0;
    if (!bus.hold) begin
      case (r_state)
        ST_IDLE, ST_DIRECT: begin
          if (w_scan_req) begin
            w_state_nxt = ST_SCAN;
            w_sel_nxt   = '0;
          end else if (bus.sel_load) begin
            w_state_nxt = ST_DIRECT;
            w_sel_nxt   = w_clamped;
          end
        end
`ifdef SRC_DATA_SEL_SCAN_EN
        ST_SCAN: begin
          if (!w_scan_req) begin
            w_state_nxt = ST_DIRECT;
          end else if (r_sel >= LAST) begin
            w_sel_nxt  = '0;
            w_wrap_nxt = 1'b1;
          end else begin
            w_sel_nxt = r_sel + 1'b1;
          end
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // out_valid: out carries data from a latched selection; there is no
  // ready/backpressure, hold is the only stall and freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (!bus.hold) begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_state_nxt != ST_IDLE) begin
        r_out   <= w_ch[w_sel_nxt];
        r_valid <= 1'b1;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.cur_sel   = r_sel;
  assign bus.scan_wrap = r_wrap & ~bus.hold;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_src_data_sel_reg.sv
// Self-checking bench for src_data_sel_reg; scan tests follow SRC_DATA_SEL_SCAN_EN.
module tb_src_data_sel_reg;
  localparam int WIDTH = 32;
  localparam int N     = 9;
  localparam int SEL_W = 4;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIRECT = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [SEL_W-1:0] sel_q[$];
  logic [WIDTH-1:0] ch [N];

  src_data_sel_reg_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

  src_data_sel_reg #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_drv
    assign bus.in_bus[k*WIDTH +: WIDTH] = ch[k];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ch();
    for (int k = 0; k < N; k++) ch[k] = 32'hA000_0000 + k;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    bus.control = 4'd5; bus.sel_load = 1'b1;
    exp_q.push_back(ch[5]); sel_q.push_back(4'd5);
    tick();
    bus.sel_load = 1'b0;
    ed = exp_q.pop_front(); es = sel_q.pop_front();
    total++; if (bus.out !== ed) begin bad++; $display("FAIL pre_reset_out got=%h exp=%h", bus.out, ed); end
    total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL pre_reset_sel got=%0d exp=%0d", bus.cur_sel, es); end
    #3 reset = 1'b1;
    #1;
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL reset_out got=%h exp=0", bus.out); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.cur_sel !== 4'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus.cur_sel); end
    total++; if (bus.scan_wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", bus.scan_wrap); end
    total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
    reset = 1'b0;
    tick();
    total++; if (bus.out !== 32'd0) begin bad++; $display("FAIL idle_out got=%h exp=0", bus.out); end
    total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL idle_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
  endtask

  task automatic test_load_track();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    bus.control = 4'd3; bus.sel_load = 1'b1;
    exp_q.push_back(32'hA000_0003); sel_q.push_back(4'd3);
    tick();
    bus.sel_load = 1'b0;
    ed = exp_q.pop_front(); es = sel_q.pop_front();
    total++; if (bus.out !== ed) begin bad++; $display("FAIL load_out got=%h exp=%h", bus.out, ed); end
    total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL load_sel got=%0d exp=%0d", bus.cur_sel, es); end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", bus.out_valid); end
    total++; if (bus.dbg_state !== S_DIRECT) begin bad++; $display("FAIL load_state got=%0d exp=%0d", bus.dbg_state, S_DIRECT); end
    ch[3] = 32'h1234_5678;
    exp_q.push_back(32'h1234_5678);
    tick();
    ed = exp_q.pop_front();
    total++; if (bus.out !== ed) begin bad++; $display("FAIL track_out got=%h exp=%h", bus.out, ed); end
  endtask

  task automatic test_clamp();
    logic [SEL_W-1:0] ctl [5] = '{4'd12, 4'd8, 4'd15, 4'd9, 4'd3};
    logic [SEL_W-1:0] esel [5] = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd3};
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    init_ch();
    for (int i = 0; i < 5; i++) begin
      bus.control = ctl[i]; bus.sel_load = 1'b1;
      exp_q.push_back(ch[esel[i]]); sel_q.push_back(esel[i]);
      tick();
      ed = exp_q.pop_front(); es = sel_q.pop_front();
      total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL clamp_sel ctl=%0d got=%0d exp=%0d", ctl[i], bus.cur_sel, es); end
      total++; if (bus.out !== ed) begin bad++; $display("FAIL clamp_out ctl=%0d got=%h exp=%h", ctl[i], bus.out, ed); end
    end
    bus.sel_load = 1'b0;
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    logic [WIDTH-1:0] held;
    bus.control = 4'd3; bus.sel_load = 1'b1;
    held = ch[3];
    exp_q.push_back(held); sel_q.push_back(4'd3);
    tick();
    ed = exp_q.pop_front(); es = sel_q.pop_front();
    total++; if (bus.out !== ed) begin bad++; $display("FAIL hold_pre_out got=%h exp=%h", bus.out, ed); end
    bus.hold = 1'b1; bus.control = 4'd5; bus.sel_load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ch[3] = $urandom;
      exp_q.push_back(held); sel_q.push_back(4'd3);
      tick();
      ed = exp_q.pop_front(); es = sel_q.pop_front();
      total++; if (bus.out !== ed) begin bad++; $display("FAIL hold_out cyc=%0d got=%h exp=%h", i, bus.out, ed); end
      total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL hold_sel cyc=%0d got=%0d exp=%0d", i, bus.cur_sel, es); end
      total++; if (bus.dbg_state !== S_DIRECT) begin bad++; $display("FAIL hold_state cyc=%0d got=%0d exp=%0d", i, bus.dbg_state, S_DIRECT); end
    end
    bus.hold = 1'b0; bus.sel_load = 1'b0;
    ch[3] = $urandom;
    exp_q.push_back(ch[3]); sel_q.push_back(4'd3);
    tick();
    ed = exp_q.pop_front(); es = sel_q.pop_front();
    total++; if (bus.out !== ed) begin bad++; $display("FAIL hold_release_out got=%h exp=%h", bus.out, ed); end
    total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL hold_release_sel got=%0d exp=%0d", bus.cur_sel, es); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    logic [SEL_W-1:0] cur;
    logic [SEL_W-1:0] c;
    logic             ld;
    cur = 4'd0;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < N; k++) ch[k] = $urandom;
      c  = SEL_W'($urandom_range(0, 15));
      ld = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ld) cur = (c > 4'd8) ? 4'd8 : c;
      bus.control = c; bus.sel_load = ld;
      exp_q.push_back(ch[cur]); sel_q.push_back(cur);
      tick();
      ed = exp_q.pop_front(); es = sel_q.pop_front();
      total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL b2b_sel cyc=%0d got=%0d exp=%0d", i, bus.cur_sel, es); end
      total++; if (bus.out !== ed) begin bad++; $display("FAIL b2b_out cyc=%0d got=%h exp=%h", i, bus.out, ed); end
    end
    bus.sel_load = 1'b0;
    init_ch();
  endtask

`ifdef SRC_DATA_SEL_SCAN_EN
  task automatic test_scan();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    bus.scan_en = 1'b1; bus.control = 4'd5;
    for (int i = 0; i < 10; i++) begin
      bus.sel_load = (i % 2 == 0);
      es = (i == 9) ? 4'd0 : SEL_W'(i);
      exp_q.push_back(ch[es]); sel_q.push_back(es);
      tick();
      ed = exp_q.pop_front(); es = sel_q.pop_front();
      total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL scan_sel cyc=%0d got=%0d exp=%0d", i, bus.cur_sel, es); end
      total++; if (bus.out !== ed) begin bad++; $display("FAIL scan_out cyc=%0d got=%h exp=%h", i, bus.out, ed); end
      total++; if (bus.scan_wrap !== (i == 9)) begin bad++; $display("FAIL scan_wrap cyc=%0d got=%b exp=%b", i, bus.scan_wrap, (i == 9)); end
      total++; if (bus.dbg_state !== S_SCAN) begin bad++; $display("FAIL scan_state cyc=%0d got=%0d exp=%0d", i, bus.dbg_state, S_SCAN); end
    end
    bus.scan_en = 1'b0; bus.sel_load = 1'b0;
    exp_q.push_back(ch[0]); sel_q.push_back(4'd0);
    tick();
    ed = exp_q.pop_front(); es = sel_q.pop_front();
    total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL scan_exit_sel got=%0d exp=%0d", bus.cur_sel, es); end
    total++; if (bus.out !== ed) begin bad++; $display("FAIL scan_exit_out got=%h exp=%h", bus.out, ed); end
    total++; if (bus.dbg_state !== S_DIRECT) begin bad++; $display("FAIL scan_exit_state got=%0d exp=%0d", bus.dbg_state, S_DIRECT); end
    total++; if (bus.scan_wrap !== 1'b0) begin bad++; $display("FAIL scan_exit_wrap got=%b exp=0", bus.scan_wrap); end
    // Reach another wrap, then reset while the pulse is high.
    bus.scan_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++; if (bus.scan_wrap !== 1'b1) begin bad++; $display("FAIL rescan_wrap got=%b exp=1", bus.scan_wrap); end
    #3 reset = 1'b1;
    #1;
    total++; if (bus.scan_wrap !== 1'b0) begin bad++; $display("FAIL reset_scan_wrap got=%b exp=0", bus.scan_wrap); end
    bus.scan_en = 1'b0;
    reset = 1'b0;
    tick();
    total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL post_reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
  endtask
`else
  task automatic test_scan_off();
    logic [WIDTH-1:0] ed;
    logic [SEL_W-1:0] es;
    bus.scan_en = 1'b1; bus.sel_load = 1'b1; bus.control = 4'd2;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ch[2]); sel_q.push_back(4'd2);
      tick();
      bus.sel_load = 1'b0;
      ed = exp_q.pop_front(); es = sel_q.pop_front();
      total++; if (bus.cur_sel !== es) begin bad++; $display("FAIL noscan_sel cyc=%0d got=%0d exp=%0d", i, bus.cur_sel, es); end
      total++; if (bus.out !== ed) begin bad++; $display("FAIL noscan_out cyc=%0d got=%h exp=%h", i, bus.out, ed); end
      total++; if (bus.scan_wrap !== 1'b0) begin bad++; $display("FAIL noscan_wrap cyc=%0d got=%b exp=0", i, bus.scan_wrap); end
      total++; if (bus.dbg_state !== S_DIRECT) begin bad++; $display("FAIL noscan_state cyc=%0d got=%0d exp=%0d", i, bus.dbg_state, S_DIRECT); end
    end
    #3 reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.dbg_state !== S_IDLE) begin bad++; $display("FAIL noscan_idle_state cyc=%0d got=%0d exp=%0d", i, bus.dbg_state, S_IDLE); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL noscan_idle_valid cyc=%0d got=%b exp=0", i, bus.out_valid); end
    end
    bus.scan_en = 1'b0;
  endtask
`endif

  initial begin
    bus.control  = '0;
    bus.sel_load = 1'b0;
    bus.hold     = 1'b0;
    bus.scan_en  = 1'b0;
    init_ch();
    #12 reset = 1'b0;
    test_reset();
    test_load_track();
    test_clamp();
    test_hold();
    test_back_to_back();
`ifdef SRC_DATA_SEL_SCAN_EN
    test_scan();
`else
    test_scan_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
